// File: rtl/ide_wdata_fifo_ctl.sv
// ide_wdata_fifo_ctl: paces a valid/ready word stream into the IDE write-data FIFO, sector-count bounded
//   clk, nRST (async, active-low)
//   start/sector_cnt : begin a transfer of sector_cnt*256 words (0 = 256 sectors), sampled in IDLE
//   abort            : synchronous cancel from any state, no done pulse
//   src_valid/src_data/src_ready : upstream handshake, src_ready combinational
//   full/almost_full/wData_fifo_usedw : FIFO status
//   wrreq/wdata      : registered FIFO write strobe and data
//   busy/done        : not-IDLE flag and one-cycle completion pulse
module ide_wdata_fifo_ctl #(
    parameter int USEDW_HI = 3000,
    parameter int USEDW_W  = 13,
    parameter int DATA_W   = 16
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               start,
    input  logic [7:0]         sector_cnt,
    input  logic               abort,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               src_ready,
    input  logic               full,
    input  logic               almost_full,
    input  logic [USEDW_W-1:0] wData_fifo_usedw,
    output logic               wrreq,
    output logic [DATA_W-1:0]  wdata,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, HS, GAP1, GAP2, GAP3, CHECK, DONE} state_t;
    state_t state, state_nxt;
    logic [16:0] remaining;
    logic cond_hs, cond_pace, xfer, last;
    assign cond_pace = !full && (32'(wData_fifo_usedw) < USEDW_HI);
    assign cond_hs   = cond_pace && !almost_full;
    assign src_ready = !abort && ((state == HS && cond_hs) || (state == CHECK && cond_pace));
    assign xfer      = src_valid && src_ready;
    assign last      = remaining == 17'd1;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (cond_hs ? HS : GAP1) : IDLE;
            HS:      state_nxt = (xfer && last) ? DONE : (cond_hs ? HS : GAP1);
            GAP1:    state_nxt = GAP2;
            GAP2:    state_nxt = GAP3;
            GAP3:    state_nxt = CHECK;
            CHECK:   state_nxt = xfer ? (last ? DONE : (cond_hs ? HS : GAP1)) : (cond_hs ? HS : CHECK);
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            remaining <= '0;
            wrreq     <= 1'b0;
            wdata     <= '0;
        end else begin
            wrreq <= xfer;
            if (xfer)
                wdata <= src_data;
            // sector_cnt of 0 encodes 256 sectors, i.e. 65536 words
            if (abort)
                remaining <= '0;
            else if (state == IDLE && start)
                remaining <= (sector_cnt == 8'd0) ? 17'h10000 : {1'b0, sector_cnt, 8'h00};
            else if (xfer)
                remaining <= remaining - 17'd1;
        end
    end
endmodule

// File: tb/tb_ide_wdata_fifo_ctl.sv
// tb_ide_wdata_fifo_ctl: scoreboard bench for the IDE write-data pacing controller
module tb_ide_wdata_fifo_ctl;
    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  sector_cnt = 8'd0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = 16'd0;
    logic        src_ready;
    logic        full = 1'b0;
    logic        almost_full = 1'b0;
    logic [12:0] usedw = 13'd0;
    logic        wrreq;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] base = 16'd0;
    logic [15:0] mon_exp;
    int          sent = 0;

    ide_wdata_fifo_ctl dut (
        .clk(clk), .nRST(nRST), .start(start), .sector_cnt(sector_cnt), .abort(abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .full(full), .almost_full(almost_full), .wData_fifo_usedw(usedw),
        .wrreq(wrreq), .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // upstream source: presents base+sent, advances on each accepted handshake
    always @(negedge clk) begin
        src_data = base + 16'(sent);
        #3;
        if (nRST && src_valid && src_ready)
            sent++;
    end

    // scoreboard: every FIFO write must match the next planned word
    always @(negedge clk) begin
        if (wrreq) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wdata_extra: got write %h, want no write", wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wdata !== mon_exp) begin
                    n_err++;
                    $display("FAIL wdata_order: got %h want %h", wdata, mon_exp);
                end
            end
        end
    end

    task automatic plan(input logic [15:0] b, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back(b + 16'(i));
        base = b;
        sent = 0;
        src_data = b;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (wrreq !== 1'b0) begin n_err++; $display("FAIL rst_wrreq: got %b want 0", wrreq); end
        n_cmp++; if (wdata !== 16'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", src_ready); end
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        logic e;
        plan(16'h1000, 256);
        src_valid = 1'b1;
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k >= 2 && k <= 257);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL burst_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== (k == 257)) begin n_err++; $display("FAIL burst_done cyc %0d: got %b", k, done); end
            n_cmp++; if (busy !== (k <= 257)) begin n_err++; $display("FAIL burst_busy cyc %0d: got %b", k, busy); end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL burst_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_paced();
        logic e;
        plan(16'h2000, 256);
        almost_full = 1'b1;
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        for (int k = 1; k <= 1028; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k % 4 == 1) && k >= 5 && k <= 1025;
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL paced_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            e = (k % 4 == 0) && k >= 4 && k <= 1024;
            n_cmp++; if (src_ready !== e) begin n_err++; $display("FAIL paced_ready cyc %0d: got %b want %b", k, src_ready, e); end
            n_cmp++; if (done !== (k == 1025)) begin n_err++; $display("FAIL paced_done cyc %0d: got %b", k, done); end
        end
        almost_full = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL paced_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_flag_burst();
        logic e;
        plan(16'h3000, 256);
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        for (int k = 1; k <= 264; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k >= 2 && k <= 50) || (k >= 55 && k <= 261);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL flag_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== (k == 261)) begin n_err++; $display("FAIL flag_done cyc %0d: got %b", k, done); end
            if (k == 50) begin
                almost_full = 1'b1;
                #1;
                n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL flag_ready: got %b want 0", src_ready); end
            end
            if (k == 51)
                almost_full = 1'b0;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL flag_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_full_stall();
        logic e;
        plan(16'h4000, 256);
        full = 1'b1;
        almost_full = 1'b1;
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        for (int k = 1; k <= 276; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k == 15) || (k >= 19 && k <= 273);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL stall_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== (k == 273)) begin n_err++; $display("FAIL stall_done cyc %0d: got %b", k, done); end
            if (k <= 13) begin
                n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready cyc %0d: got %b want 0", k, src_ready); end
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy cyc %0d: got %b want 1", k, busy); end
            end
            if (k == 14) begin
                full = 1'b0;
                #1;
                n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", src_ready); end
            end
            if (k == 15)
                almost_full = 1'b0;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    task automatic test_usedw_edge();
        logic e;
        plan(16'h5000, 256);
        usedw = 13'd3000;
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        for (int k = 1; k <= 267; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k >= 9 && k <= 264);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL usedw_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== (k == 264)) begin n_err++; $display("FAIL usedw_done cyc %0d: got %b", k, done); end
            if (k <= 7) begin
                n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL usedw_ready cyc %0d: got %b want 0", k, src_ready); end
            end
            if (k == 8) begin
                usedw = 13'd2999;
                #1;
                n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL usedw_release: got %b want 1", src_ready); end
            end
        end
        usedw = 13'd0;
    endtask

    task automatic test_abort();
        logic e;
        plan(16'h6000, 512);
        @(negedge clk); sector_cnt = 8'd2; start = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk); start = 1'b0;
            e = (k >= 2 && k <= 101);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL abort_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done cyc %0d: got %b want 0", k, done); end
            n_cmp++; if (busy !== (k <= 101)) begin n_err++; $display("FAIL abort_busy cyc %0d: got %b", k, busy); end
            if (k == 101) begin
                abort = 1'b1;
                #1;
                n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", src_ready); end
            end
            if (k == 102)
                abort = 1'b0;
        end
        n_cmp++; if (sent != 100) begin n_err++; $display("FAIL abort_count: got %0d accepted want 100", sent); end
    endtask

    task automatic test_reset_mid();
        plan(16'h7000, 256);
        @(negedge clk); sector_cnt = 8'd1; start = 1'b1;
        repeat (50) begin
            @(negedge clk); start = 1'b0;
        end
        #2 nRST = 1'b0;
        #1;
        n_cmp++; if (wrreq !== 1'b0) begin n_err++; $display("FAIL rmid_wrreq: got %b want 0", wrreq); end
        n_cmp++; if (wdata !== 16'd0) begin n_err++; $display("FAIL rmid_wdata: got %h want 0", wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", done); end
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b want 0", src_ready); end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (wrreq !== 1'b0) begin n_err++; $display("FAIL rmid_post_wrreq %0d: got %b want 0", k, wrreq); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_post_busy %0d: got %b want 0", k, busy); end
        end
    endtask

    task automatic test_count_boundary();
        logic e;
        plan(16'h0000, 65536);
        @(negedge clk); sector_cnt = 8'd0; start = 1'b1;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk); start = 1'b0; sector_cnt = 8'd0;
            e = (k >= 2 && k <= 65537);
            n_cmp++; if (wrreq !== e) begin n_err++; $display("FAIL cnt_wrreq cyc %0d: got %b want %b", k, wrreq, e); end
            n_cmp++; if (done !== (k == 65537)) begin n_err++; $display("FAIL cnt_done cyc %0d: got %b", k, done); end
            // a start while busy must not reload the count
            if (k == 100) begin
                sector_cnt = 8'd1;
                start = 1'b1;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL cnt_left: got %0d words unwritten want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_paced();
        test_flag_burst();
        test_full_stall();
        test_usedw_edge();
        test_abort();
        test_reset_mid();
        test_count_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
